// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter sharing a single-port data memory
// Optional bus locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_read_i,
    input  logic [3:0]  m0_wsel_byte_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_read_i,
    input  logic [3:0]  m1_wsel_byte_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

`ifdef DMEM_ARB_LOCK_EN
    input  logic        m0_lock_i,
    input  logic        m1_lock_i,
`endif

    output logic        mem_en_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_read_o,
    output logic [3:0]  mem_wsel_byte_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int LAST = MEM_LATENCY - 1;

    // Round-robin pointer: 0 means port 0 wins the next conflict.
    logic rr_q;
    logic rr_d;

    // Granted port id for this cycle and whether any grant happens.
    logic sel;
    logic gnt_any;
    logic elig0;
    logic elig1;

    // Response pipeline: valid, requester id and read flag per stage.
    logic [MEM_LATENCY-1:0] pv_q;
    logic [MEM_LATENCY-1:0] pid_q;
    logic [MEM_LATENCY-1:0] prd_q;

`ifdef DMEM_ARB_LOCK_EN
    logic own_vld_q;
    logic own_vld_d;
    logic own_id_q;
    logic own_id_d;
    logic lock_sel;

    // A locked owner shuts the other port out of arbitration.
    always_comb begin
        elig0 = m0_req_i & (~own_vld_q | ~own_id_q);
        elig1 = m1_req_i & (~own_vld_q |  own_id_q);
    end
`else
    // Without locking every requester is eligible every cycle.
    always_comb begin
        elig0 = m0_req_i;
        elig1 = m1_req_i;
    end
`endif

    // Pick the winner: a lone requester wins, conflicts use priority or the pointer.
    always_comb begin
        sel     = 1'b0;
        gnt_any = elig0 | elig1;
        if (elig0 && elig1) begin
            sel = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
        end else if (elig1) begin
            sel = 1'b1;
        end
        m0_gnt_o = gnt_any & ~sel;
        m1_gnt_o = gnt_any &  sel;
        // The pointer moves only on a grant, to favour the other port next time.
        rr_d     = gnt_any ? ~sel : rr_q;
    end

    // Drive the winner's payload onto the memory; a read never carries byte enables.
    always_comb begin
        mem_en_o        = gnt_any;
        mem_addr_o      = 32'h0;
        mem_read_o      = 1'b0;
        mem_wsel_byte_o = 4'h0;
        mem_wdata_o     = 32'h0;
        if (gnt_any) begin
            if (sel) begin
                mem_addr_o      = m1_addr_i;
                mem_read_o      = m1_read_i;
                mem_wsel_byte_o = m1_read_i ? 4'h0 : m1_wsel_byte_i;
                mem_wdata_o     = m1_wdata_i;
            end else begin
                mem_addr_o      = m0_addr_i;
                mem_read_o      = m0_read_i;
                mem_wsel_byte_o = m0_read_i ? 4'h0 : m0_wsel_byte_i;
                mem_wdata_o     = m0_wdata_i;
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Owner is taken by a locked grant and dropped by the owner's first unlocked grant.
    always_comb begin
        lock_sel  = sel ? m1_lock_i : m0_lock_i;
        own_vld_d = own_vld_q;
        own_id_d  = own_id_q;
        if (gnt_any) begin
            if (lock_sel) begin
                own_vld_d = 1'b1;
                own_id_d  = sel;
            end else begin
                own_vld_d = 1'b0;
            end
        end
    end

    // Owner register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            own_vld_q <= 1'b0;
            own_id_q  <= 1'b0;
        end else begin
            own_vld_q <= own_vld_d;
            own_id_q  <= own_id_d;
        end
    end
`endif

    // Pointer register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Shift every cycle so a response pops out exactly MEM_LATENCY cycles after its grant.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pv_q  <= '0;
            pid_q <= '0;
            prd_q <= '0;
        end else begin
            pv_q[0]  <= gnt_any;
            pid_q[0] <= sel;
            prd_q[0] <= mem_read_o;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pid_q[i] <= pid_q[i-1];
                prd_q[i] <= prd_q[i-1];
            end
        end
    end

    // Route the output stage to its requester; writes return a zero-data acknowledge.
    always_comb begin
        m0_rvalid_o = pv_q[LAST] & ~pid_q[LAST];
        m1_rvalid_o = pv_q[LAST] &  pid_q[LAST];
        m0_rdata_o  = (m0_rvalid_o & prd_q[LAST]) ? mem_rdata_i : 32'h0;
        m1_rdata_o  = (m1_rvalid_o & prd_q[LAST]) ? mem_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic clk;
    logic rstn;

    logic        m0_req [3];
    logic        m0_gnt [3];
    logic [31:0] m0_addr [3];
    logic        m0_read [3];
    logic [3:0]  m0_wsel [3];
    logic [31:0] m0_wdata [3];
    logic        m0_rvalid [3];
    logic [31:0] m0_rdata [3];
    logic        m1_req [3];
    logic        m1_gnt [3];
    logic [31:0] m1_addr [3];
    logic        m1_read [3];
    logic [3:0]  m1_wsel [3];
    logic [31:0] m1_wdata [3];
    logic        m1_rvalid [3];
    logic [31:0] m1_rdata [3];
`ifdef DMEM_ARB_LOCK_EN
    logic        m0_lock [3];
    logic        m1_lock [3];
`endif
    logic        mem_en [3];
    logic [31:0] mem_addr [3];
    logic        mem_read [3];
    logic [3:0]  mem_wsel [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    logic        pl_en;
    int          pl_inst;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int n_chk;
    int n_fail;

    always #5 clk = ~clk;

    // Instance 0: latency 1 round-robin, 1: latency 1 fixed priority, 2: latency 3 round-robin.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int FP  = (g == 1) ? 1 : 0;

        logic [31:0] mem [256];
        logic [31:0] rpipe [LAT];
        logic [7:0]  idx;

        assign idx          = mem_addr[g][9:2];
        assign mem_rdata[g] = rpipe[LAT-1];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            for (int i = 0; i < LAT; i++) rpipe[i] = 32'h0;
        end

        always @(posedge clk) begin
            if (pl_en && pl_inst == g) begin
                mem[pl_idx] <= pl_data;
            end else if (mem_en[g] && !mem_read[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wsel[g][b]) mem[idx][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            rpipe[0] <= mem[idx];
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end

        dmem_arbiter #(.MEM_LATENCY(LAT), .FIXED_PRIO(FP)) u_dut (
            .clk_i          (clk),
            .rstn_i         (rstn),
            .m0_req_i       (m0_req[g]),
            .m0_gnt_o       (m0_gnt[g]),
            .m0_addr_i      (m0_addr[g]),
            .m0_read_i      (m0_read[g]),
            .m0_wsel_byte_i (m0_wsel[g]),
            .m0_wdata_i     (m0_wdata[g]),
            .m0_rvalid_o    (m0_rvalid[g]),
            .m0_rdata_o     (m0_rdata[g]),
            .m1_req_i       (m1_req[g]),
            .m1_gnt_o       (m1_gnt[g]),
            .m1_addr_i      (m1_addr[g]),
            .m1_read_i      (m1_read[g]),
            .m1_wsel_byte_i (m1_wsel[g]),
            .m1_wdata_i     (m1_wdata[g]),
            .m1_rvalid_o    (m1_rvalid[g]),
            .m1_rdata_o     (m1_rdata[g]),
`ifdef DMEM_ARB_LOCK_EN
            .m0_lock_i      (m0_lock[g]),
            .m1_lock_i      (m1_lock[g]),
`endif
            .mem_en_o       (mem_en[g]),
            .mem_addr_o     (mem_addr[g]),
            .mem_read_o     (mem_read[g]),
            .mem_wsel_byte_o(mem_wsel[g]),
            .mem_wdata_o    (mem_wdata[g]),
            .mem_rdata_i    (mem_rdata[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            m0_req[i] = 0; m0_addr[i] = 0; m0_read[i] = 0; m0_wsel[i] = 0; m0_wdata[i] = 0;
            m1_req[i] = 0; m1_addr[i] = 0; m1_read[i] = 0; m1_wsel[i] = 0; m1_wdata[i] = 0;
`ifdef DMEM_ARB_LOCK_EN
            m0_lock[i] = 0; m1_lock[i] = 0;
`endif
        end
    endtask

    task automatic do_reset();
        rstn = 0;
        next();
        rstn = 1;
    endtask

    task automatic preload(input int inst, input logic [7:0] idx, input logic [31:0] data);
        pl_inst = inst; pl_idx = idx; pl_data = data; pl_en = 1;
        next();
        pl_en = 0;
    endtask

    task automatic check_idle(input int inst, input string tag);
        check({tag, "_gnt0"},   {31'h0, m0_gnt[inst]}, 0);
        check({tag, "_gnt1"},   {31'h0, m1_gnt[inst]}, 0);
        check({tag, "_rv0"},    {31'h0, m0_rvalid[inst]}, 0);
        check({tag, "_rv1"},    {31'h0, m1_rvalid[inst]}, 0);
        check({tag, "_rd0"},    m0_rdata[inst], 0);
        check({tag, "_rd1"},    m1_rdata[inst], 0);
        check({tag, "_en"},     {31'h0, mem_en[inst]}, 0);
        check({tag, "_addr"},   mem_addr[inst], 0);
        check({tag, "_mread"},  {31'h0, mem_read[inst]}, 0);
        check({tag, "_wsel"},   {28'h0, mem_wsel[inst]}, 0);
        check({tag, "_wdata"},  mem_wdata[inst], 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        clk = 0; rstn = 0; pl_en = 0; pl_inst = 0; pl_idx = 0; pl_data = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, $sformatf("rst%0d", i));
        next();
        rstn = 1;
        preload(0, 8'd64, 32'hDEADBEEF);
        preload(0, 8'd16, 32'h11223344);

        // Single read from port 0.
        m0_req[0] = 1; m0_read[0] = 1; m0_addr[0] = 32'h100;
        @(negedge clk);
        check("t1_gnt0", {31'h0, m0_gnt[0]}, 1);
        check("t1_gnt1", {31'h0, m1_gnt[0]}, 0);
        check("t1_en",   {31'h0, mem_en[0]}, 1);
        check("t1_addr", mem_addr[0], 32'h100);
        check("t1_mread", {31'h0, mem_read[0]}, 1);
        next();
        m0_req[0] = 0;
        @(negedge clk);
        check("t1_rv0", {31'h0, m0_rvalid[0]}, 1);
        check("t1_rd0", m0_rdata[0], 32'hDEADBEEF);
        check("t1_rv1", {31'h0, m1_rvalid[0]}, 0);
        check("t1_idle_en", {31'h0, mem_en[0]}, 0);
        check("t1_idle_addr", mem_addr[0], 0);
        next();
        @(negedge clk);
        check("t1_rv0_off", {31'h0, m0_rvalid[0]}, 0);
        next();

        // Round-robin alternation under continuous conflict.
        do_reset();
        m0_req[0] = 1; m0_read[0] = 1; m0_addr[0] = 32'h100;
        m1_req[0] = 1; m1_read[0] = 1; m1_addr[0] = 32'h40;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t2_gnt0_%0d", i), {31'h0, m0_gnt[0]}, (i % 2 == 0) ? 1 : 0);
            check($sformatf("t2_gnt1_%0d", i), {31'h0, m1_gnt[0]}, (i % 2 == 1) ? 1 : 0);
            check($sformatf("t2_en_%0d", i),   {31'h0, mem_en[0]}, 1);
            if (i > 0) begin
                check($sformatf("t2_rv0_%0d", i), {31'h0, m0_rvalid[0]}, ((i-1) % 2 == 0) ? 1 : 0);
                check($sformatf("t2_rv1_%0d", i), {31'h0, m1_rvalid[0]}, ((i-1) % 2 == 1) ? 1 : 0);
            end
            next();
        end
        m0_req[0] = 0; m1_req[0] = 0;
        @(negedge clk);
        check("t2_rv1_last", {31'h0, m1_rvalid[0]}, 1);
        check("t2_rv0_last", {31'h0, m0_rvalid[0]}, 0);
        check("t2_rd1_last", m1_rdata[0], 32'h11223344);
        next();

        // Fixed priority: port 0 always wins, port 1 served once port 0 leaves.
        m0_req[1] = 1; m0_read[1] = 1;
        m1_req[1] = 1; m1_read[1] = 1; m1_addr[1] = 32'h8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t3_gnt0_%0d", i), {31'h0, m0_gnt[1]}, 1);
            check($sformatf("t3_gnt1_%0d", i), {31'h0, m1_gnt[1]}, 0);
            next();
        end
        m0_req[1] = 0;
        @(negedge clk);
        check("t3_gnt1_after", {31'h0, m1_gnt[1]}, 1);
        check("t3_addr_after", mem_addr[1], 32'h8);
        next();
        clear_inputs();

        // Same-address conflict: read sees old data, write then lands with byte enables.
        do_reset();
        m0_req[0] = 1; m0_read[0] = 1; m0_addr[0] = 32'h40; m0_wsel[0] = 4'hF;
        m1_req[0] = 1; m1_read[0] = 0; m1_addr[0] = 32'h40; m1_wsel[0] = 4'b0011;
        m1_wdata[0] = 32'hA5A5A5A5;
        @(negedge clk);
        check("t4_gnt0", {31'h0, m0_gnt[0]}, 1);
        check("t4_gnt1", {31'h0, m1_gnt[0]}, 0);
        check("t4_rd_wsel", {28'h0, mem_wsel[0]}, 0);
        next();
        m0_req[0] = 0;
        @(negedge clk);
        check("t4_gnt1_b", {31'h0, m1_gnt[0]}, 1);
        check("t4_wr_wsel", {28'h0, mem_wsel[0]}, 4'b0011);
        check("t4_wr_mread", {31'h0, mem_read[0]}, 0);
        check("t4_wr_wdata", mem_wdata[0], 32'hA5A5A5A5);
        check("t4_rv0_old", {31'h0, m0_rvalid[0]}, 1);
        check("t4_rd0_old", m0_rdata[0], 32'h11223344);
        next();
        m1_req[0] = 0;
        m0_req[0] = 1;
        @(negedge clk);
        check("t4_gnt0_c", {31'h0, m0_gnt[0]}, 1);
        check("t4_rv1_ack", {31'h0, m1_rvalid[0]}, 1);
        check("t4_rd1_ack", m1_rdata[0], 0);
        next();
        m0_req[0] = 0;
        @(negedge clk);
        check("t4_rv0_new", {31'h0, m0_rvalid[0]}, 1);
        check("t4_rd0_low", {16'h0, m0_rdata[0][15:0]}, 32'h0000A5A5);
        check("t4_rd0_full", m0_rdata[0], 32'h1122A5A5);
        next();
        clear_inputs();

        // Latency 3 with reset while three accesses are in flight.
        do_reset();
        m0_req[2] = 1; m0_read[2] = 1;
        @(negedge clk);
        check("t5_g0", {31'h0, m0_gnt[2]}, 1);
        next();
        m0_req[2] = 0; m1_req[2] = 1; m1_read[2] = 1;
        @(negedge clk);
        check("t5_g1", {31'h0, m1_gnt[2]}, 1);
        check("t5_rv_a", {31'h0, m0_rvalid[2]}, 0);
        next();
        m1_req[2] = 0; m0_req[2] = 1;
        @(negedge clk);
        check("t5_g2", {31'h0, m0_gnt[2]}, 1);
        check("t5_rv_b", {31'h0, m0_rvalid[2]}, 0);
        next();
        m0_req[2] = 0;
        rstn = 0;
        @(negedge clk);
        check_idle(2, "t5_inrst");
        next();
        rstn = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t5_post_rv0_%0d", i), {31'h0, m0_rvalid[2]}, 0);
            check($sformatf("t5_post_rv1_%0d", i), {31'h0, m1_rvalid[2]}, 0);
            next();
        end

`ifdef DMEM_ARB_LOCK_EN
        // Port 1 holds the bus through two locked accesses and releases on the third.
        do_reset();
        m1_req[0] = 1; m1_read[0] = 1; m1_addr[0] = 32'h40; m1_lock[0] = 1;
        @(negedge clk);
        check("t6_g1_a", {31'h0, m1_gnt[0]}, 1);
        next();
        m0_req[0] = 1; m0_read[0] = 1; m0_addr[0] = 32'h100;
        @(negedge clk);
        check("t6_g0_b", {31'h0, m0_gnt[0]}, 0);
        check("t6_g1_b", {31'h0, m1_gnt[0]}, 1);
        next();
        m1_lock[0] = 0;
        @(negedge clk);
        check("t6_g0_c", {31'h0, m0_gnt[0]}, 0);
        check("t6_g1_c", {31'h0, m1_gnt[0]}, 1);
        next();
        m1_req[0] = 0;
        @(negedge clk);
        check("t6_g0_d", {31'h0, m0_gnt[0]}, 1);
        next();
        clear_inputs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (sp_mem, registered read) between two requesters: port 0 is the core data port and port 1 is a secondary master (debug/DMA/loader).
- Sits between yarc_platform's dmem interface and the dmem instance in the FPGA top.
- Performs per-cycle arbitration and drives the memory enable, address, read and byte-select signals.
- Tracks in-flight accesses so each response returns to the requester that issued it.

Parameters:
- MEM_LATENCY, 1: cycles from memory enable to valid rdata_i. Legal values are 1..4.
- FIXED_PRIO, 0: 0 selects round-robin; 1 gives port 0 fixed priority.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- m0_req_i  in  1  port 0 access request
- m0_gnt_o  out  1  port 0 request accepted this cycle
- m0_addr_i  in  32  port 0 byte address
- m0_read_i  in  1  1 = read, 0 = write
- m0_wsel_byte_i  in  4  port 0 write byte enables
- m0_wdata_i  in  32  port 0 write data
- m0_rvalid_o  out  1  port 0 response valid
- m0_rdata_o  out  32  port 0 read data
- m1_*  same set as m0_* for port 1
- mem_en_o  out  1  memory enable
- mem_addr_o  out  32  byte address (top slices [31:2])
- mem_read_o  out  1  memory read strobe
- mem_wsel_byte_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data

Behaviour:
- Clock and reset: one clock, clk_i. rstn_i is asynchronous, active-low.
- Reset values:
  - All state clears.
  - Round-robin pointer = port 0 preferred.
  - m*_rvalid_o = 0; response pipeline empty.
  - mem_en_o, m*_gnt_o = 0 whenever both req are 0.
- Handshake:
  - Requester holds req and all payload stable until it sees gnt=1.
  - gnt is combinational, issued in the same cycle the access is driven to memory.
  - Acceptance is req & gnt at the clock edge.
  - At most one gnt per cycle; zero wait states when there is no conflict.
- Arbitration:
  - Single request: granted immediately.
  - Both requesting, FIXED_PRIO=0: grant the port not granted most recently. The pointer updates only on a grant.
  - Both requesting, FIXED_PRIO=1: port 0 always wins. Port 1 may starve; this is documented and intended for debug use.
- Memory mux:
  - The granted port's addr/read/wsel/wdata drive mem_* combinationally.
  - mem_en_o = |gnt.
  - When idle, mem_* payload = 0 and mem_read_o = 0.
  - A write is forced to wsel = 0 when read = 1 (a read never writes).
- Response tracking:
  - MEM_LATENCY-deep shift register of {valid, id}, pushed every cycle with {mem_en_o, granted id}.
  - Output stage valid & id==k → mk_rvalid_o = 1, exactly MEM_LATENCY cycles after the grant.
  - Reads and writes both return rvalid; a write rvalid is the acknowledge.
  - mk_rdata_o = mem_rdata_i when read, else 0. The read flag is tracked in the pipeline alongside valid/id.
- Pipelining: back-to-back grants every cycle are allowed, with no bubble between ports. Responses return in issue order.
- Reset mid-operation: in-flight entries are discarded and no rvalid is emitted after reset deasserts. The memory contents are untouched by the arbiter.
- Requests from both ports for the same address in the same cycle: serialized by the arbiter, loser sees the winner's write.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - Extra inputs m0_lock_i and m1_lock_i, 1 bit each.
  - A grant accepted with lock=1 latches owner = that port.
  - While owner is set, only the owner can be granted. The other port's gnt stays 0.
  - Lock is released on the first owner-accepted access with lock=0, or on reset.
  - Simultaneous lock requests resolve by the normal arbitration.
- Without the macro: no lock ports and no owner register; behaviour is pure arbitration.

Test Plan:
1. m0 read addr 0x100 alone, MEM_LATENCY=1, memory holds 0xDEADBEEF → m0_gnt_o=1 in the same cycle, mem_addr_o=0x100; next cycle m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF; m1_rvalid_o stays 0.
2. Both ports request continuously for 6 cycles, FIXED_PRIO=0 → grants alternate 0,1,0,1,0,1; every cycle mem_en_o=1; rvalids alternate with a 1-cycle lag.
3. Same stimulus with FIXED_PRIO=1 → m0 granted all 6 cycles, m1_gnt_o=0 throughout; m1 is granted in the first cycle after m0 drops req.
4. m1 writes 0xA5A5A5A5 to 0x40 with wsel=4'b0011 while m0 reads 0x40 in the same cycle (round-robin, pointer at port 0) → m0 is granted first and reads the old value; then m1 writes; a subsequent m0 read returns the low half = 0xA5A5.
5. MEM_LATENCY=3: m0, m1, m0 grants in consecutive cycles; rstn_i asserted one cycle after the third grant → no rvalid appears after reset and all outputs are 0 during reset.
6. DMEM_ARB_LOCK_EN: m1 issues 3 accesses with lock=1,1,0 while m0 requests continuously → m0_gnt_o=0 until m1's third access is accepted, then m0 is granted the next cycle.
